stage_mem_sb: RTL

Parametrised successor to the pipeline memory stage. It adds a SB_DEPTH-entry FIFO store buffer, so stores retire without waiting for RAM. Loads are forwarded from the buffer when an exact match exists. Sits between EX/MEM and MEM/WB latches, owns the single RAM port, and produces the stall_mem request for the hazard unit.

---
 rtl/stage_mem_sb_pkg.sv | 24 ++
 rtl/stage_mem_sb_if.sv | 32 +++
 rtl/stage_mem_sb_store_buffer.sv | 113 +++++++++++
 rtl/stage_mem_sb.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/stage_mem_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_sb_pkg
// Purpose  : Shared bus widths, access-length codes and memory-stage FSM states.
// Revision : 1.0  initial release
// ============================================================================
package stage_mem_sb_pkg;

    localparam int c_MEM_ADDR_W = 32;
    localparam int c_REG_W      = 32;
    localparam int c_REG_ADDR_W = 5;

    localparam logic [2:0] c_LEN_B = 3'd1;
    localparam logic [2:0] c_LEN_H = 3'd2;
    localparam logic [2:0] c_LEN_W = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } mem_state_t;

endpackage
`default_nettype wire

// File: rtl/stage_mem_sb_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_sb_if
// Purpose  : Single-port RAM request/response bus owned by the memory stage.
// Revision : 1.0  initial release
// ============================================================================
interface stage_mem_sb_if
    import stage_mem_sb_pkg::*;
#(
    parameter int ADDR_WIDTH = c_MEM_ADDR_W,
    parameter int DATA_WIDTH = c_REG_W
);
    logic                  ram_ready;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data_i;
    logic [DATA_WIDTH-1:0] ram_data_o;
    logic [2:0]            ram_length;
    logic                  ram_signed;
    logic                  ram_read;
    logic                  ram_write;

    modport master (
        input  ram_ready, ram_data_i,
        output ram_addr, ram_data_o, ram_length, ram_signed, ram_read, ram_write
    );

    modport slave (
        output ram_ready, ram_data_i,
        input  ram_addr, ram_data_o, ram_length, ram_signed, ram_read, ram_write
    );
endinterface
`default_nettype wire

// File: rtl/stage_mem_sb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_sb_store_buffer
// Purpose  : FIFO of pending stores with a youngest-overlap search for loads.
// Revision : 1.0  initial release
// ============================================================================
module stage_mem_sb_store_buffer
    import stage_mem_sb_pkg::*;
#(
    parameter int SB_DEPTH   = 4,
    parameter int ADDR_WIDTH = c_MEM_ADDR_W,
    parameter int DATA_WIDTH = c_REG_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic [2:0]            push_length,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    input  logic [2:0]            lookup_length,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [2:0]            head_length,
    output logic                  hit,
    output logic                  partial,
    output logic [DATA_WIDTH-1:0] hit_data
);
    localparam int               c_PTR_W = $clog2(SB_DEPTH);
    localparam logic [c_PTR_W:0] c_DEPTH = (c_PTR_W+1)'(SB_DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr   [SB_DEPTH];
    logic [DATA_WIDTH-1:0] r_data   [SB_DEPTH];
    logic [2:0]            r_length [SB_DEPTH];
    logic [c_PTR_W-1:0]    r_head;
    logic [c_PTR_W-1:0]    r_tail;
    logic [c_PTR_W:0]      r_count;

    logic [c_PTR_W-1:0]    w_slot [SB_DEPTH];
    logic [SB_DEPTH-1:0]   w_live;
    logic                  w_found;
    logic                  w_exact;
    logic [DATA_WIDTH-1:0] w_found_data;

    // One extra bit on the range ends keeps the top of the address space from wrapping.
    function automatic logic overlaps(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] a_len,
                                      input logic [ADDR_WIDTH-1:0] b, input logic [2:0] b_len);
        logic [ADDR_WIDTH:0] a_end;
        logic [ADDR_WIDTH:0] b_end;
        a_end = {1'b0, a} + {{(ADDR_WIDTH-2){1'b0}}, a_len};
        b_end = {1'b0, b} + {{(ADDR_WIDTH-2){1'b0}}, b_len};
        return ({1'b0, a} < b_end) && ({1'b0, b} < a_end);
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            r_addr[r_tail]   <= push_addr;
            r_data[r_tail]   <= push_data;
            r_length[r_tail] <= push_length;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (push) r_tail <= r_tail + 1'b1;
            if (pop)  r_head <= r_head + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: ;
            endcase
        end
    end

    // Slot g holds the g-th oldest entry; later slots are younger.
    for (genvar g = 0; g < SB_DEPTH; g++) begin : g_slot
        assign w_slot[g] = r_head + c_PTR_W'(g);
        assign w_live[g] = (c_PTR_W+1)'(g) < r_count;
    end

    always_comb begin
        w_found      = 1'b0;
        w_exact      = 1'b0;
        w_found_data = '0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (w_live[i] && overlaps(r_addr[w_slot[i]], r_length[w_slot[i]],
                                      lookup_addr, lookup_length)) begin
                w_found      = 1'b1;
                w_exact      = (r_addr[w_slot[i]] == lookup_addr) &&
                               (r_length[w_slot[i]] == lookup_length);
                w_found_data = r_data[w_slot[i]];
            end
        end
    end

    assign full        = (r_count == c_DEPTH);
    assign empty       = (r_count == '0);
    assign head_addr   = r_addr[r_head];
    assign head_data   = r_data[r_head];
    assign head_length = r_length[r_head];
    assign hit         = w_found && w_exact;
    assign partial     = w_found && !w_exact;
    assign hit_data    = w_found_data;

endmodule
`default_nettype wire

// File: rtl/stage_mem_sb.sv
`default_nettype none
// ============================================================================
// Module   : stage_mem_sb
// Purpose  : Pipeline memory stage with store buffer, load forwarding and RAM FSM.
// Revision : 1.0  initial release
// ============================================================================
module stage_mem_sb
    import stage_mem_sb_pkg::*;
#(
    parameter int SB_DEPTH   = 4,
    parameter int ADDR_WIDTH = c_MEM_ADDR_W,
    parameter int DATA_WIDTH = c_REG_W
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic                    store,
    input  logic                    fence,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   data,
    input  logic [2:0]              length,
    input  logic                    signed_,
    output logic                    stall_mem,
    stage_mem_sb_if.master          ram,
    input  logic                    write_i,
    input  logic [c_REG_ADDR_W-1:0] regw_addr_i,
    input  logic [DATA_WIDTH-1:0]   regw_data_i,
    output logic                    write_o,
    output logic [c_REG_ADDR_W-1:0] regw_addr_o,
    output logic [DATA_WIDTH-1:0]   regw_data_o,
    output logic                    sb_empty
);
    mem_state_t            r_state;
    logic [ADDR_WIDTH-1:0] r_ld_addr;
    logic [2:0]            r_ld_length;
    logic                  r_ld_signed;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_hit;
    logic                  w_partial;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_read_done;
    logic                  w_need_read;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [2:0]            w_head_length;
    logic [DATA_WIDTH-1:0] w_hit_data;

    function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                     input logic [2:0] len, input logic sgn);
        logic [DATA_WIDTH-1:0] res;
        case (len)
            c_LEN_B: res = {{(DATA_WIDTH-8){sgn & d[7]}}, d[7:0]};
            c_LEN_H: res = {{(DATA_WIDTH-16){sgn & d[15]}}, d[15:0]};
            c_LEN_W: res = d;
            default: res = d;
        endcase
        return res;
    endfunction

    assign w_pop       = (r_state == ST_WRITE) && ram.ram_ready;
    assign w_read_done = (r_state == ST_READ) && ram.ram_ready;
    // A full buffer still accepts a store in the cycle its head drains.
    assign w_push      = store && (!w_full || w_pop);
    assign w_need_read = load && !w_hit && !w_partial;

    stage_mem_sb_store_buffer #(
        .SB_DEPTH   (SB_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .push          (w_push),
        .push_addr     (addr),
        .push_data     (data),
        .push_length   (length),
        .pop           (w_pop),
        .lookup_addr   (addr),
        .lookup_length (length),
        .full          (w_full),
        .empty         (w_empty),
        .head_addr     (w_head_addr),
        .head_data     (w_head_data),
        .head_length   (w_head_length),
        .hit           (w_hit),
        .partial       (w_partial),
        .hit_data      (w_hit_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ld_addr   <= '0;
            r_ld_length <= '0;
            r_ld_signed <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_need_read) begin
                        r_state     <= ST_READ;
                        r_ld_addr   <= addr;
                        r_ld_length <= length;
                        r_ld_signed <= signed_;
                    end else if (!w_empty) begin
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: if (ram.ram_ready) r_state <= ST_IDLE;
                ST_READ:  if (ram.ram_ready) r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        ram.ram_addr   = '0;
        ram.ram_data_o = '0;
        ram.ram_length = '0;
        ram.ram_signed = 1'b0;
        ram.ram_read   = 1'b0;
        ram.ram_write  = 1'b0;
        case (r_state)
            ST_WRITE: begin
                ram.ram_addr   = w_head_addr;
                ram.ram_data_o = w_head_data;
                ram.ram_length = w_head_length;
                ram.ram_write  = 1'b1;
            end
            ST_READ: begin
                ram.ram_addr   = r_ld_addr;
                ram.ram_length = r_ld_length;
                ram.ram_signed = r_ld_signed;
                ram.ram_read   = 1'b1;
            end
            default: ;
        endcase
    end

    assign stall_mem   = !reset && ((store && w_full && !w_pop) ||
                                    (load && !w_hit && !w_read_done) ||
                                    (fence && !w_empty));
    assign write_o     = !reset && write_i;
    assign regw_addr_o = reset ? '0 : regw_addr_i;
    assign regw_data_o = reset ? '0 :
                         !load ? regw_data_i :
                         w_hit ? extend(w_hit_data, length, signed_) : ram.ram_data_i;
    assign sb_empty    = w_empty;

endmodule
`default_nettype wire
